// File: rtl/uart_pkg.sv
// Shared constants for the UART receive FIFO: entry layout and default depth.
package uart_pkg;
    localparam int RX_ENTRY_W    = 10;
    localparam int RX_ENT_PERR   = 8;
    localparam int RX_ENT_FERR   = 9;
    localparam int RX_DEPTH_LOG2 = 4;

    typedef struct packed {
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } rx_entry_t;

    function automatic rx_entry_t rx_pack(input logic [7:0] d, input logic pe, input logic fe);
        rx_entry_t e;
        e.ferr = fe;
        e.perr = pe;
        e.data = d;
        return e;
    endfunction
endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-side and consumer-side signals of the UART receive FIFO.
// err_drop exists only when UART_RX_FIFO_DROP_ERR_EN is defined.
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = RX_DEPTH_LOG2
);
    logic [7:0]          Rx_DATA;
    logic                Rx_VALID;
    logic                Rx_PERROR;
    logic                Rx_FERROR;
    logic                rd_en;
    logic [7:0]          rd_data;
    logic                rd_perror;
    logic                rd_ferror;
    logic                rd_valid;
    logic                empty;
    logic                full;
    logic [DEPTH_LOG2:0] count;
    logic                overrun;
    logic                ovr_clr;
`ifdef UART_RX_FIFO_DROP_ERR_EN
    logic                err_drop;
`endif

    modport slave (
        input  Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR, rd_en, ovr_clr,
        output rd_data, rd_perror, rd_ferror, rd_valid, empty, full, count, overrun
`ifdef UART_RX_FIFO_DROP_ERR_EN
        , output err_drop
`endif
    );

    modport master (
        output Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR, rd_en, ovr_clr,
        input  rd_data, rd_perror, rd_ferror, rd_valid, empty, full, count, overrun
`ifdef UART_RX_FIFO_DROP_ERR_EN
        , input err_drop
`endif
    );
endinterface

// File: rtl/uart_fifo_mem.sv
// Dual-pointer storage array: synchronous write, registered synchronous read.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int W          = RX_ENTRY_W,
    parameter int DEPTH_LOG2 = RX_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_waddr,
    input  logic [W-1:0]          i_wdata,
    input  logic                  i_re,
    input  logic [DEPTH_LOG2-1:0] i_raddr,
    output logic [W-1:0]          o_rdata
);
    logic [W-1:0] r_mem [2**DEPTH_LOG2];
    logic [W-1:0] r_rdata;

    always_ff @(posedge clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;

    // Read sees the pre-write contents, so a full-FIFO read+write on one slot is safe.
    always_ff @(posedge clk or negedge reset)
        if (!reset)    r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_raddr];

    assign o_rdata = r_rdata;
endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: Rx_VALID edge detect, pointers, occupancy, overrun.
// Optional UART_RX_FIFO_DROP_ERR_EN: discard errored bytes and flag err_drop.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = RX_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_rx_fifo_if.slave         bus
);
    localparam logic [DEPTH_LOG2:0]   DEPTH   = (DEPTH_LOG2+1)'(1) << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    logic                  r_valid_q;
    logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_empty, r_full, r_overrun, r_rd_valid;
    logic                  w_wr, w_wr_ok, w_rd, w_push, w_ovr;
    logic [DEPTH_LOG2:0]   w_cnt_nxt;
    rx_entry_t             w_wdata, w_rdata;

    assign w_wr    = bus.Rx_VALID & ~r_valid_q;
    assign w_wdata = rx_pack(bus.Rx_DATA, bus.Rx_PERROR, bus.Rx_FERROR);
    assign w_rd    = bus.rd_en & ~r_empty;

`ifdef UART_RX_FIFO_DROP_ERR_EN
    logic r_err_drop;
    logic w_err;
    assign w_err   = bus.Rx_PERROR | bus.Rx_FERROR;
    assign w_wr_ok = w_wr & ~w_err;

    always_ff @(posedge clk or negedge reset)
        if (!reset)             r_err_drop <= 1'b0;
        else if (w_wr & w_err)  r_err_drop <= 1'b1;
        else if (bus.ovr_clr)   r_err_drop <= 1'b0;

    assign bus.err_drop = r_err_drop;
`else
    assign w_wr_ok = w_wr;
`endif

    // A read in the same cycle frees the slot a full-FIFO write needs.
    assign w_push = w_wr_ok & (~r_full | w_rd);
    assign w_ovr  = w_wr_ok & r_full & ~w_rd;

    always_comb begin
        w_cnt_nxt = r_count;
        if (w_push & ~w_rd)      w_cnt_nxt = r_count + CNT_ONE;
        else if (w_rd & ~w_push) w_cnt_nxt = r_count - CNT_ONE;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_valid_q  <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_overrun  <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_valid_q  <= bus.Rx_VALID;
            r_rd_valid <= w_rd;
            r_count    <= w_cnt_nxt;
            r_empty    <= (w_cnt_nxt == '0);
            r_full     <= (w_cnt_nxt == DEPTH);
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_rd)   r_rd_ptr <= r_rd_ptr + PTR_ONE;
            if (w_ovr)            r_overrun <= 1'b1;
            else if (bus.ovr_clr) r_overrun <= 1'b0;
        end

    uart_fifo_mem #(.W(RX_ENTRY_W), .DEPTH_LOG2(DEPTH_LOG2)) u_mem (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_re    (w_rd),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    assign bus.rd_data  = w_rdata.data;
`ifdef UART_RX_FIFO_DROP_ERR_EN
    assign bus.rd_perror = 1'b0;
    assign bus.rd_ferror = 1'b0;
`else
    assign bus.rd_perror = w_rdata.perr;
    assign bus.rd_ferror = w_rdata.ferr;
`endif
    assign bus.rd_valid = r_rd_valid;
    assign bus.empty    = r_empty;
    assign bus.full     = r_full;
    assign bus.count    = r_count;
    assign bus.overrun  = r_overrun;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed test-plan steps plus random traffic vs a queue model.
module tb_uart_rx_fifo;
    localparam int DL2   = 4;
    localparam int DEPTH = 1 << DL2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    uart_rx_fifo_if #(.DEPTH_LOG2(DL2)) bus ();

    uart_rx_fifo #(.DEPTH_LOG2(DL2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of {ferr,perr,data} plus sticky flags.
    logic [9:0] q[$];
    logic [9:0] m_last;
    logic       m_rvld, m_ovr, m_prev, m_edrop;

    task automatic model_reset();
        q.delete();
        m_last = '0; m_rvld = 0; m_ovr = 0; m_prev = 0; m_edrop = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rd_valid"},  32'(bus.rd_valid),  32'(m_rvld));
        chk({tag, ".rd_data"},   32'(bus.rd_data),   32'(m_last[7:0]));
        chk({tag, ".rd_perror"}, 32'(bus.rd_perror), 32'(m_last[8]));
        chk({tag, ".rd_ferror"}, 32'(bus.rd_ferror), 32'(m_last[9]));
        chk({tag, ".count"},     32'(bus.count),     32'(q.size()));
        chk({tag, ".empty"},     32'(bus.empty),     32'(q.size() == 0));
        chk({tag, ".full"},      32'(bus.full),      32'(q.size() == DEPTH));
        chk({tag, ".overrun"},   32'(bus.overrun),   32'(m_ovr));
`ifdef UART_RX_FIFO_DROP_ERR_EN
        chk({tag, ".err_drop"},  32'(bus.err_drop),  32'(m_edrop));
`endif
    endtask

    task automatic step(input string tag, input logic v, input logic [7:0] d,
                        input logic pe, input logic fe, input logic re, input logic oc);
        logic wr, rd, ovr_set;
        bus.Rx_VALID = v; bus.Rx_DATA = d; bus.Rx_PERROR = pe; bus.Rx_FERROR = fe;
        bus.rd_en = re; bus.ovr_clr = oc;
        @(posedge clk);
        wr = v && !m_prev;
        m_prev = v;
        rd = re && (q.size() > 0);
        m_rvld = rd;
        if (rd) m_last = q.pop_front();
        ovr_set = 0;
`ifdef UART_RX_FIFO_DROP_ERR_EN
        if (wr && (pe || fe)) begin m_edrop = 1; wr = 0; end
        else if (oc) m_edrop = 0;
`endif
        if (wr) begin
            if (q.size() < DEPTH) q.push_back({fe, pe, d});
            else ovr_set = 1;
        end
        if (ovr_set) m_ovr = 1;
        else if (oc) m_ovr = 0;
        #1;
        check_all(tag);
    endtask

    task automatic wr_byte(input string tag, input logic [7:0] d, input logic pe, input logic fe);
        step(tag, 1, d, pe, fe, 0, 0);
        step(tag, 0, 8'h00, 0, 0, 0, 0);
    endtask

    task automatic rd_one(input string tag);
        step(tag, 0, 8'h00, 0, 0, 1, 0);
    endtask

    initial begin
        bus.Rx_VALID = 0; bus.Rx_DATA = 0; bus.Rx_PERROR = 0; bus.Rx_FERROR = 0;
        bus.rd_en = 0; bus.ovr_clr = 0;
        model_reset();
        #3 reset = 1'b0;
        #1 check_all("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Long Rx_VALID level yields a single entry.
        for (int i = 0; i < 40; i++) step("hold", 1, 8'hAA, 0, 0, 0, 0);
        chk("hold.one_entry", 32'(bus.count), 32'd1);
        step("hold_drop", 0, 8'h00, 0, 0, 0, 0);
        rd_one("hold_rd");
        chk("hold.aa", 32'(bus.rd_data), 32'hAA);
        chk("hold.empty_after", 32'(bus.empty), 32'd1);
        step("hold_idle", 0, 8'h00, 0, 0, 0, 0);
        chk("hold.pulse_ends", 32'(bus.rd_valid), 32'd0);

        // Fill, overflow with 0x55, drain in order.
        for (int i = 0; i < 16; i++) wr_byte("fill", 8'(i), 0, 0);
        wr_byte("ovf", 8'h55, 0, 0);
        chk("ovf.full", 32'(bus.full), 32'd1);
        chk("ovf.overrun", 32'(bus.overrun), 32'd1);
        for (int i = 0; i < 16; i++) begin
            rd_one("drain");
            chk("drain.order", 32'(bus.rd_data), 32'(i));
        end
        step("ovr_clr", 0, 8'h00, 0, 0, 0, 1);
        chk("ovr_clr.cleared", 32'(bus.overrun), 32'd0);

        // Write + read in the same cycle while full.
        for (int i = 0; i < 16; i++) wr_byte("fill2", 8'(8'h10 + i), 0, 0);
        step("full_rw", 1, 8'h55, 0, 0, 1, 0);
        chk("full_rw.count", 32'(bus.count), 32'd16);
        chk("full_rw.no_ovr", 32'(bus.overrun), 32'd0);
        step("full_rw_lo", 0, 8'h00, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) rd_one("drain2");
        chk("drain2.last55", 32'(bus.rd_data), 32'h55);

        // Error flags travel with the byte (or are dropped when configured).
        wr_byte("perr", 8'h3C, 1, 0);
        wr_byte("ferr", 8'hC3, 0, 1);
`ifdef UART_RX_FIFO_DROP_ERR_EN
        chk("errdrop.count", 32'(bus.count), 32'd0);
        chk("errdrop.flag", 32'(bus.err_drop), 32'd1);
`else
        rd_one("perr_rd");
        chk("perr_rd.flags", 32'({bus.rd_ferror, bus.rd_perror, bus.rd_data}), 32'h13C);
        rd_one("ferr_rd");
        chk("ferr_rd.flags", 32'({bus.rd_ferror, bus.rd_perror, bus.rd_data}), 32'h2C3);
`endif

        // Reads while empty are ignored.
        for (int i = 0; i < 5; i++) rd_one("rd_empty");
        chk("rd_empty.count", 32'(bus.count), 32'd0);

        // Simultaneous write and rd_en while empty: write kept, read ignored.
        step("wr_rd_empty", 1, 8'h77, 0, 0, 1, 0);
        chk("wr_rd_empty.no_vld", 32'(bus.rd_valid), 32'd0);
        step("wr_rd_empty_lo", 0, 8'h00, 0, 0, 0, 0);
        rd_one("wr_rd_empty_pop");
        chk("wr_rd_empty.data", 32'(bus.rd_data), 32'h77);

        // ovr_clr coinciding with an overrun event: set wins.
        for (int i = 0; i < 16; i++) wr_byte("fill3", 8'($urandom), 0, 0);
        step("ovr_set_wins", 1, 8'hEE, 0, 0, 0, 1);
        chk("ovr_set_wins.flag", 32'(bus.overrun), 32'd1);
        step("ovr_set_wins_lo", 0, 8'h00, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++) rd_one("drain3");

        // Asynchronous reset mid-fill.
        for (int i = 0; i < 7; i++) wr_byte("fill7", 8'(8'h60 + i), 0, 0);
        chk("fill7.count", 32'(bus.count), 32'd7);
        reset = 1'b0;
        model_reset();
        #1 check_all("rst_mid");
        #1 reset = 1'b1;
        wr_byte("post_rst", 8'h81, 0, 0);
        rd_one("post_rst_rd");
        chk("post_rst.first", 32'(bus.rd_data), 32'h81);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step("rand",
                 1'($urandom_range(0, 1)),
                 8'($urandom),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 9) < (i < 300 ? 2 : 6)),
                 ($urandom_range(0, 15) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer directly downstream of the UART receiver state machine.
- Captures each received byte and its error flags once per Rx_VALID assertion, and stores them in a circular FIFO.
- Presents stored bytes to a host/consumer through a registered read port.
- Tracks occupancy and flags overrun when the receiver delivers a byte into a full buffer.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (depth = 16 entries); legal range 1..8.

Ports:
- clk  input  1  system clock, same domain as the receiver
- reset  input  1  asynchronous, active-low reset
- Rx_DATA  input  8  received byte from the receiver
- Rx_VALID  input  1  receiver valid level; may stay high for many clk cycles per byte
- Rx_PERROR  input  1  receiver parity error, qualified by Rx_VALID
- Rx_FERROR  input  1  receiver framing error, qualified by Rx_VALID
- rd_en  input  1  consumer read request
- rd_data  output  8  byte popped by the last accepted read
- rd_perror  output  1  parity error flag stored with rd_data
- rd_ferror  output  1  framing error flag stored with rd_data
- rd_valid  output  1  one-cycle pulse: rd_data/rd_*error updated this cycle
- empty  output  1  FIFO holds 0 entries
- full  output  1  FIFO holds 2**DEPTH_LOG2 entries
- count  output  DEPTH_LOG2+1  current occupancy
- overrun  output  1  sticky: a byte was lost because the FIFO was full
- ovr_clr  input  1  clears overrun

Behaviour:
- Reset (reset=0, async) forces the following values immediately:
  - rd_data=0, rd_perror=0, rd_ferror=0, rd_valid=0
  - empty=1, full=0, count=0, overrun=0
  - read/write pointers=0, valid_q=0
- In-flight entries are discarded on reset.
- Write strobe: valid_q registers Rx_VALID each cycle; wr = Rx_VALID & ~valid_q.
  - Exactly one write per rising edge of Rx_VALID, regardless of how long Rx_VALID stays high.
  - Rx_DATA/Rx_PERROR/Rx_FERROR are sampled in the wr cycle.
- Entry is 10 bits: {ferr, perr, data[7:0]}.
- Write when not full: store at wr_ptr; wr_ptr increments modulo depth.
- Write when full with no accepted read in the same cycle: entry dropped, overrun<=1, pointers unchanged.
- Read: rd_en & ~empty pops the entry at rd_ptr.
  - rd_data/rd_perror/rd_ferror are registered and valid in the next cycle with rd_valid=1 (latency 1).
  - rd_ptr increments modulo depth.
- rd_en while empty: ignored; rd_valid stays 0 and outputs hold their previous values.
- Simultaneous wr and accepted read:
  - Both take effect and count is unchanged.
  - When full, the read frees a slot, so the write is stored and overrun is not set.
- Simultaneous wr and rd_en while empty: the write is stored and the read is ignored; a new rd_en is required to pop it.
- count: +1 on write only, -1 on read only; never exceeds 2**DEPTH_LOG2 and never goes below 0.
- empty = (count==0); full = (count==2**DEPTH_LOG2); both are registered, consistent with count.
- ovr_clr and an overrun event in the same cycle: set wins.
- Pointers are DEPTH_LOG2 bits wide and wrap naturally; count disambiguates full from empty.

Optional Feature:
- Macro: UART_RX_FIFO_DROP_ERR_EN.
- Defined:
  - Entries with Rx_PERROR|Rx_FERROR at the wr strobe are not stored and do not set overrun.
  - A separate sticky output err_drop (1 bit, reset 0, cleared by ovr_clr) is set instead.
  - rd_perror/rd_ferror are tied to 0.
- Undefined:
  - All bytes are stored with their flags as described above.
  - err_drop port is absent.

Decomposition:
- Package uart_pkg holds:
  - RX_ENTRY_W=10
  - bit indices RX_ENT_PERR=8, RX_ENT_FERR=9
  - default DEPTH_LOG2=4
- Sub-module uart_fifo_mem: synchronous-write, synchronous-read dual-pointer storage array, parameterised on width and DEPTH_LOG2.
- The top module holds the edge detect, pointers, count, flags and the drop logic.

Test Plan:
- Rx_VALID held high 40 cycles with Rx_DATA=8'hAA, then rd_en 1 cycle -> exactly one entry (count=1), rd_data=8'hAA, rd_valid pulse one cycle after rd_en, empty=1 afterwards.
- Write 16 bytes 8'h00..8'h0F, then a 17th 8'h55 -> full=1, count=16, overrun=1; drain 16 reads -> data 8'h00..8'h0F in order, empty=1; 8'h55 never appears.
- With FIFO full, a wr strobe in the same cycle as rd_en -> count stays 16, overrun stays 0, last read returns 8'h55 after draining.
- Byte 8'h3C with Rx_PERROR=1, then 8'hC3 with Rx_FERROR=1 -> reads return (3C, perr=1, ferr=0) then (C3, perr=0, ferr=1); with UART_RX_FIFO_DROP_ERR_EN defined -> count=0, err_drop=1.
- rd_en while empty for 5 cycles -> rd_valid=0, rd_data unchanged, count=0; ovr_clr coinciding with an overrun event -> overrun=1.
- reset asserted low mid-fill at count=7 -> outputs immediately at reset values, count=0, empty=1; after release, a new byte 8'h81 reads back first.
